// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

    // Access sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Contents of the MEM/WB pipeline register.
    typedef struct packed {
        logic        regwrite;
        logic        mem2reg;
        logic [4:0]  reg_dest;
        logic [31:0] instr;
        logic [63:0] alu_val;
        logic [63:0] read_data;
    } memwb_t;

    // A bubble writes nothing back and carries a zero instruction word.
    localparam memwb_t MEMWB_BUBBLE = {1'b0, 1'b0, 5'd0, 32'd0, 64'd0, 64'd0};

    // Doubleword accesses must sit on an 8-byte boundary.
    function automatic logic is_misaligned(input logic [63:0] addr);
        return (addr[2:0] != 3'b000);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a new entry, inserts a bubble, or holds.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   bubble,
    input  memwb_t d,
    output memwb_t q
);

    memwb_t q_r;

    // Register update; bubble takes precedence over load.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= MEMWB_BUBBLE;
        end else if (bubble) begin
            q_r <= MEMWB_BUBBLE;
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives the req/ack data-memory port, resolves zero-branches,
// stalls upstream during multi-cycle accesses and feeds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] ALU_VAL_IN,
    input  logic [63:0] RT_READ_IN,
    input  logic [63:0] BRANCH_IN,
    input  logic        ZERO_IN,
    input  logic [4:0]  REG_DESTINATION_IN,
    input  logic        REGWRITE_IN,
    input  logic        MEM2REG_IN,
    input  logic        MEMWRITE_IN,
    input  logic        MEMREAD_IN,
    input  logic        BRANCH_ZERO_IN,
    input  logic [31:0] INSTR_IN,
    input  logic        DMEM_ACK,
    input  logic [63:0] DMEM_RDATA,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [63:0] DMEM_ADDR,
    output logic [63:0] DMEM_WDATA,
    output logic        STALL,
    output logic        PC_SRC,
    output logic [63:0] BRANCH_TARGET,
    output logic        MEM_FAULT,
    output logic [63:0] READ_DATA_OUT,
    output logic [63:0] ALU_VAL_OUT,
    output logic [4:0]  REG_DESTINATION_OUT,
    output logic        REGWRITE_OUT,
    output logic        MEM2REG_OUT,
    output logic [31:0] INSTR_OUT
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              req_r;
    logic              we_r;
    logic [63:0]       addr_r;
    logic [63:0]       wdata_r;
    logic              fault_r;

    logic              mem_op_s;
    logic              misalign_s;
    logic              stall_s;
    logic              start_s;
    logic              req_end_s;
    logic              fault_set_s;
    logic              cnt_inc_s;
    logic              wb_load_s;
    logic              wb_bubble_s;
    logic              take_rdata_s;
    memwb_t            wb_d_s;
    memwb_t            wb_q_s;

    assign mem_op_s   = MEMREAD_IN | MEMWRITE_IN;
    assign misalign_s = mem_op_s & is_misaligned(ALU_VAL_IN);

    // Next-state and per-cycle control of the access sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        stall_s      = 1'b0;
        start_s      = 1'b0;
        req_end_s    = 1'b0;
        fault_set_s  = 1'b0;
        cnt_inc_s    = 1'b0;
        wb_load_s    = 1'b0;
        wb_bubble_s  = 1'b0;
        take_rdata_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (misalign_s) begin
                    fault_set_s = 1'b1;
                    wb_bubble_s = 1'b1;
                end else if (mem_op_s) begin
                    stall_s     = 1'b1;
                    start_s     = 1'b1;
                    wb_bubble_s = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    wb_load_s   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (DMEM_ACK) begin
                    // ACK beats a coincident timeout.
                    wb_load_s    = 1'b1;
                    take_rdata_s = ~we_r;
                    req_end_s    = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    fault_set_s  = 1'b1;
                    wb_bubble_s  = 1'b1;
                    req_end_s    = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    stall_s      = 1'b1;
                    cnt_inc_s    = 1'b1;
                    wb_bubble_s  = 1'b1;
                end
            end
            default: begin
                wb_bubble_s = 1'b1;
                req_end_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Entry presented to MEM/WB; a store never writes the register file.
    always_comb begin
        wb_d_s           = MEMWB_BUBBLE;
        wb_d_s.regwrite  = REGWRITE_IN & ~MEMWRITE_IN;
        wb_d_s.mem2reg   = MEM2REG_IN;
        wb_d_s.reg_dest  = REG_DESTINATION_IN;
        wb_d_s.instr     = INSTR_IN;
        wb_d_s.alu_val   = ALU_VAL_IN;
        if (take_rdata_s) begin
            wb_d_s.read_data = DMEM_RDATA;
        end else begin
            wb_d_s.read_data = 64'd0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Wait counter: cleared when an access starts, counts unacknowledged cycles.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (start_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Memory port registers; address, data and direction frozen during the access.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 64'd0;
            wdata_r <= 64'd0;
        end else if (start_s) begin
            req_r   <= 1'b1;
            we_r    <= MEMWRITE_IN;
            addr_r  <= ALU_VAL_IN;
            wdata_r <= RT_READ_IN;
        end else if (req_end_s) begin
            req_r   <= 1'b0;
        end else begin
            req_r   <= req_r;
        end
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fault_r <= 1'b0;
        end else if (fault_set_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (CLK),
        .reset  (RESET),
        .load   (wb_load_s),
        .bubble (wb_bubble_s),
        .d      (wb_d_s),
        .q      (wb_q_s)
    );

    assign DMEM_REQ            = req_r;
    assign DMEM_WE             = we_r;
    assign DMEM_ADDR           = addr_r;
    assign DMEM_WDATA          = wdata_r;
    assign STALL               = stall_s;
    assign PC_SRC              = BRANCH_ZERO_IN & ZERO_IN;
    assign BRANCH_TARGET       = BRANCH_IN;
    assign MEM_FAULT           = fault_r;
    assign READ_DATA_OUT       = wb_q_s.read_data;
    assign ALU_VAL_OUT         = wb_q_s.alu_val;
    assign REG_DESTINATION_OUT = wb_q_s.reg_dest;
    assign REGWRITE_OUT        = wb_q_s.regwrite;
    assign MEM2REG_OUT         = wb_q_s.mem2reg;
    assign INSTR_OUT           = wb_q_s.instr;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB entries are queued on issue
// and compared when the stage retires the instruction.
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [63:0] ALU_VAL_IN, RT_READ_IN, BRANCH_IN, DMEM_RDATA;
    logic        ZERO_IN, REGWRITE_IN, MEM2REG_IN, MEMWRITE_IN, MEMREAD_IN, BRANCH_ZERO_IN, DMEM_ACK;
    logic [4:0]  REG_DESTINATION_IN;
    logic [31:0] INSTR_IN;
    logic        DMEM_REQ, DMEM_WE, STALL, PC_SRC, MEM_FAULT, REGWRITE_OUT, MEM2REG_OUT;
    logic [63:0] DMEM_ADDR, DMEM_WDATA, BRANCH_TARGET, READ_DATA_OUT, ALU_VAL_OUT;
    logic [4:0]  REG_DESTINATION_OUT;
    logic [31:0] INSTR_OUT;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] instr;
        logic [63:0] alu;
        logic [63:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_fault = 1'b0;

    mem_stage dut (
        .CLK(CLK), .RESET(RESET), .ALU_VAL_IN(ALU_VAL_IN), .RT_READ_IN(RT_READ_IN),
        .BRANCH_IN(BRANCH_IN), .ZERO_IN(ZERO_IN), .REG_DESTINATION_IN(REG_DESTINATION_IN),
        .REGWRITE_IN(REGWRITE_IN), .MEM2REG_IN(MEM2REG_IN), .MEMWRITE_IN(MEMWRITE_IN),
        .MEMREAD_IN(MEMREAD_IN), .BRANCH_ZERO_IN(BRANCH_ZERO_IN), .INSTR_IN(INSTR_IN),
        .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
        .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .STALL(STALL), .PC_SRC(PC_SRC),
        .BRANCH_TARGET(BRANCH_TARGET), .MEM_FAULT(MEM_FAULT), .READ_DATA_OUT(READ_DATA_OUT),
        .ALU_VAL_OUT(ALU_VAL_OUT), .REG_DESTINATION_OUT(REG_DESTINATION_OUT),
        .REGWRITE_OUT(REGWRITE_OUT), .MEM2REG_OUT(MEM2REG_OUT), .INSTR_OUT(INSTR_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic nop();
        ALU_VAL_IN = 64'd0; RT_READ_IN = 64'd0; BRANCH_IN = 64'd0; ZERO_IN = 1'b0;
        REG_DESTINATION_IN = 5'd0; REGWRITE_IN = 1'b0; MEM2REG_IN = 1'b0;
        MEMWRITE_IN = 1'b0; MEMREAD_IN = 1'b0; BRANCH_ZERO_IN = 1'b0; INSTR_IN = 32'd0;
    endtask

    task automatic check_wb(input string name, input exp_t e);
        exp_t got;
        got = {REGWRITE_OUT, MEM2REG_OUT, REG_DESTINATION_OUT, INSTR_OUT, ALU_VAL_OUT, READ_DATA_OUT};
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s memwb: got rw=%b m2r=%b rd=%0d instr=%h alu=%h rdata=%h want rw=%b m2r=%b rd=%0d instr=%h alu=%h rdata=%h",
                     name, got.rw, got.m2r, got.rd, got.instr, got.alu, got.rdata,
                     e.rw, e.m2r, e.rd, e.instr, e.alu, e.rdata);
        end
    endtask

    // Issue one EX/MEM instruction, answer the memory port, compare on retire.
    task automatic run_op(input string name, input logic rd_f, input logic wr_f,
                          input logic rw_f, input logic m2r_f, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [4:0] rdst,
                          input logic [31:0] instr, input int ack_at, input logic [63:0] rdata);
        exp_t e;
        logic is_mem, mis, tmo;
        int   exp_stall, exp_req, stall_seen, req_seen;
        logic done;
        is_mem = rd_f | wr_f;
        mis    = is_mem && (addr[2:0] != 3'b000);
        tmo    = is_mem && !mis && (ack_at == 0 || ack_at > 16);
        if (mis || tmo) begin
            e = '0;
        end else begin
            e.rw    = rw_f & ~wr_f;
            e.m2r   = m2r_f;
            e.rd    = rdst;
            e.instr = instr;
            e.alu   = addr;
            e.rdata = (rd_f && !wr_f) ? rdata : 64'd0;
        end
        exp_req   = (!is_mem || mis) ? 0 : (tmo ? 16 : ack_at);
        exp_stall = exp_req;
        exp_fault = exp_fault | mis | tmo;
        sb.push_back(e);

        ALU_VAL_IN = addr; RT_READ_IN = wdata; REG_DESTINATION_IN = rdst;
        REGWRITE_IN = rw_f; MEM2REG_IN = m2r_f; MEMWRITE_IN = wr_f; MEMREAD_IN = rd_f;
        INSTR_IN = instr;
        stall_seen = 0; req_seen = 0; done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (DMEM_REQ === 1'b1) begin
                req_seen++;
                n_cmp++;
                if ({DMEM_WE, DMEM_ADDR, DMEM_WDATA} !== {wr_f, addr, wdata}) begin
                    n_err++;
                    $display("FAIL %s port: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                             name, DMEM_WE, DMEM_ADDR, DMEM_WDATA, wr_f, addr, wdata);
                end
                if (req_seen == ack_at) begin
                    DMEM_ACK = 1'b1; DMEM_RDATA = rdata;
                end
            end
            #1;
            if (STALL === 1'b1) stall_seen++;
            else done = 1'b1;
            @(posedge CLK); #1;
            DMEM_ACK = 1'b0; DMEM_RDATA = 64'd0;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s retire: stall still high after 40 cycles, want low", name);
        end
        n_cmp++;
        if (stall_seen != exp_stall) begin
            n_err++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_seen, exp_stall);
        end
        n_cmp++;
        if (req_seen != exp_req) begin
            n_err++;
            $display("FAIL %s req_cycles: got %0d want %0d", name, req_seen, exp_req);
        end
        n_cmp++;
        if (DMEM_REQ !== 1'b0) begin
            n_err++;
            $display("FAIL %s req_after: got %b want 0", name, DMEM_REQ);
        end
        n_cmp++;
        if (MEM_FAULT !== exp_fault) begin
            n_err++;
            $display("FAIL %s fault: got %b want %b", name, MEM_FAULT, exp_fault);
        end
        check_wb(name, sb.pop_front());
    endtask

    task automatic do_reset();
        RESET = 1'b1; DMEM_ACK = 1'b0; DMEM_RDATA = 64'd0;
        nop();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_fault = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, STALL, MEM_FAULT} !== 131'd0) begin
            n_err++;
            $display("FAIL reset port: got req=%b we=%b addr=%h wdata=%h stall=%b fault=%b want all 0",
                     DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, STALL, MEM_FAULT);
        end
        check_wb("reset", '0);
    endtask

    task automatic test_load();
        run_op("ldur", 1'b1, 1'b0, 1'b1, 1'b1, 64'h40, 64'h0, 5'd3, 32'hF8400001, 1, 64'hDEAD);
        nop();
    endtask

    task automatic test_store();
        run_op("stur", 1'b0, 1'b1, 1'b1, 1'b0, 64'h80, 64'h1234, 5'd7, 32'hF8000002, 4, 64'hBEEF);
        nop();
    endtask

    task automatic test_alu_pass();
        run_op("alu", 1'b0, 1'b0, 1'b1, 1'b0, 64'h5555_0000_1234_5678, 64'h9, 5'd12, 32'h8B020020, 0, 64'h0);
        nop();
    endtask

    task automatic test_back_to_back();
        run_op("b2b_a", 1'b1, 1'b0, 1'b1, 1'b1, 64'h8, 64'h0, 5'd4, 32'hF8400003, 1, 64'h1111);
        run_op("b2b_b", 1'b1, 1'b0, 1'b1, 1'b1, 64'h10, 64'h0, 5'd5, 32'hF8400004, 2, 64'h2222);
        run_op("both", 1'b1, 1'b1, 1'b1, 1'b1, 64'h18, 64'hABCD, 5'd6, 32'hF8000005, 1, 64'h3333);
        nop();
    endtask

    task automatic test_branch();
        BRANCH_ZERO_IN = 1'b1; ZERO_IN = 1'b1; BRANCH_IN = 64'h100;
        #1;
        n_cmp++;
        if ({PC_SRC, BRANCH_TARGET, STALL} !== {1'b1, 64'h100, 1'b0}) begin
            n_err++;
            $display("FAIL cbz_taken: got pc_src=%b target=%h stall=%b want 1 100 0",
                     PC_SRC, BRANCH_TARGET, STALL);
        end
        ZERO_IN = 1'b0;
        #1;
        n_cmp++;
        if (PC_SRC !== 1'b0) begin
            n_err++;
            $display("FAIL cbz_not_taken: got pc_src=%b want 0", PC_SRC);
        end
        nop();
        @(posedge CLK); #1;
    endtask

    task automatic test_misalign();
        do_reset();
        run_op("misalign", 1'b1, 1'b0, 1'b1, 1'b1, 64'h43, 64'h0, 5'd9, 32'hF8400006, 1, 64'h77);
        nop();
    endtask

    task automatic test_timeout();
        do_reset();
        run_op("timeout", 1'b1, 1'b0, 1'b1, 1'b1, 64'h200, 64'h0, 5'd10, 32'hF8400007, 0, 64'h0);
        nop();
        run_op("resume", 1'b1, 1'b0, 1'b1, 1'b1, 64'h208, 64'h0, 5'd11, 32'hF8400008, 1, 64'hCAFE);
        nop();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        ALU_VAL_IN = 64'h300; MEMREAD_IN = 1'b1; REGWRITE_IN = 1'b1; MEM2REG_IN = 1'b1;
        REG_DESTINATION_IN = 5'd2; INSTR_IN = 32'hF8400009;
        repeat (2) begin @(posedge CLK); #1; end
        n_cmp++;
        if (DMEM_REQ !== 1'b1) begin
            n_err++;
            $display("FAIL rst_wait_req_before: got %b want 1", DMEM_REQ);
        end
        RESET = 1'b1;
        nop();
        @(posedge CLK); #1;
        RESET = 1'b0;
        n_cmp++;
        if (DMEM_REQ !== 1'b0) begin
            n_err++;
            $display("FAIL rst_wait_req_after: got %b want 0", DMEM_REQ);
        end
        DMEM_ACK = 1'b1; DMEM_RDATA = 64'hFEED;
        #1;
        n_cmp++;
        if (STALL !== 1'b0) begin
            n_err++;
            $display("FAIL late_ack_stall: got %b want 0", STALL);
        end
        @(posedge CLK); #1;
        DMEM_ACK = 1'b0; DMEM_RDATA = 64'd0;
        n_cmp++;
        if ({DMEM_REQ, MEM_FAULT} !== 2'b00) begin
            n_err++;
            $display("FAIL late_ack_port: got req=%b fault=%b want 0 0", DMEM_REQ, MEM_FAULT);
        end
        check_wb("late_ack", '0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_alu_pass();
        test_back_to_back();
        test_branch();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
